bus_port_fifo_bank: RTL and testbench
=====================================

Name: bus_port_fifo_bank

Overview:
Per-driver FIFO bank between the agent/driver side and the bus generator/arbiter port of each device.
- Each of `drvrs` channels has two FIFOs:
  - a TX FIFO: the agent writes; the bus sees `pndng`/`D_pop` and pops.
  - an RX FIFO: the bus pushes with `push`/`D_push`; the monitor side reads.
- Generalises the single-channel fifo with parametrised depth and channel count, almost-full signalling, sticky error flags and a selectable RX overflow policy.

Parameters:
- pckg_sz, 16, packet width in bits.
- drvrs, 4, number of channels (≥1).
- deep_fifo, 8, entries per FIFO (≥2, any integer, not only powers of two).
- af_lvl, 6, tx_afull asserts when TX occupancy ≥ af_lvl (1 ≤ af_lvl ≤ deep_fifo).
- rx_drop_old, 0, RX overflow policy: 0 = discard incoming packet, 1 = overwrite oldest entry.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- clr_err  in  1  synchronous clear of all sticky error flags.
- wr_en  in  drvrs  agent push into TX FIFO i.
- wr_data  in  drvrs*pckg_sz  TX write data, channel i at bits [i*pckg_sz +: pckg_sz].
- tx_full  out  drvrs  TX FIFO i holds deep_fifo entries.
- tx_afull  out  drvrs  TX occupancy ≥ af_lvl.
- pndng  out  drvrs  TX FIFO i non-empty.
- pop  in  drvrs  bus consumes TX head of channel i.
- D_pop  out  drvrs*pckg_sz  TX head of channel i (first-word fall-through).
- push  in  drvrs  bus delivers packet to channel i.
- D_push  in  drvrs*pckg_sz  RX write data.
- rd_en  in  drvrs  monitor consumes RX head of channel i.
- rx_valid  out  drvrs  RX FIFO i non-empty.
- rd_data  out  drvrs*pckg_sz  RX head of channel i (first-word fall-through).
- tx_ovf  out  drvrs  sticky: wr_en while full, with no same-cycle pop.
- rx_ovf  out  drvrs  sticky: push while RX full, with no same-cycle rd_en.
- udf  out  drvrs  sticky: pop on empty TX or rd_en on empty RX.

Behaviour:
- **Reset** (reset=0 at a clk edge): all pointers and counts go to 0 and all flags to 0.
  - pndng=0, rx_valid=0, tx_full=0, tx_afull=0 (af_lvl ≥ 1).
  - D_pop=0 and rd_data=0 while the FIFO is empty.
  - Reset dominates every same-cycle write, read and clr_err.
  - Reset mid-operation discards all stored packets.
- **Channel independence:** channels are fully independent; there is no arbitration inside the block.
- **FIFO structure:** each FIFO uses read/write pointers in 0..deep_fifo-1 and a count in 0..deep_fifo.
  - Pointers wrap from deep_fifo-1 to 0.
  - All status outputs are registered functions of count and update in the cycle after the causing edge.
- **Latency:** first-word fall-through.
  - A write at edge N makes the data visible on D_pop/rd_data and raises pndng/rx_valid after edge N.
  - A pop at edge N exposes the next entry after edge N.
  - D_pop and rd_data hold their value when the FIFO is empty.
- **TX write:**
  - wr_en && !full → store and increment count.
  - wr_en && full && !pop → drop the data and set tx_ovf.
  - wr_en && full && pop → pop the head, store the new data; count stays at deep_fifo and no error.
- **TX pop:**
  - pop && count>0 → advance the read pointer.
  - pop && empty → no state change, set udf.
  - pop and wr_en together on an empty FIFO → the write is stored and udf is set.
- **RX push:**
  - push && !full → store.
  - Full, rd_en in the same cycle → behaves as simultaneous read + write; no error.
  - Full, no rd_en, rx_drop_old=0 → incoming packet discarded, set rx_ovf.
  - Full, no rd_en, rx_drop_old=1 → advance both pointers so the new packet replaces the oldest; count stays at deep_fifo; set rx_ovf.
- **RX read:** rd_en follows the same rules as TX pop (udf on empty).
- **Sticky flags:** cleared only by reset or clr_err. If clr_err coincides with a new error event, the flag ends at 1 (set wins).
- **Count update:** count' = count + accepted_write − accepted_read, where accepted_* already excludes dropped and empty operations.

Optional Feature:
- **Macro:** FIFO_STATS_EN.
- **When defined**, the block adds these outputs:
  - tx_occ and rx_occ, each drvrs*$clog2(deep_fifo+1) bits: current count per FIFO.
  - drop_cnt, drvrs*8 bits: per-channel saturating counter (stops at 255) of dropped or overwritten packets, TX plus RX. A TX and an RX drop in the same cycle add 2.
  - drop_cnt resets to 0 on reset only; it is not affected by clr_err.
- **When undefined**, these ports and their logic do not exist, and behaviour is otherwise identical.

Test Plan:
- **Depth boundary:** reset; channel 2 writes 0x0202, then 8 further values 0x0001..0x0008 back-to-back. Required:
  - pndng[2]=1 one cycle after the first write.
  - D_pop[2]=0x0202.
  - tx_full[2]=1 after 8 entries and tx_afull[2]=1 at 6 entries.
  - The 9th write is dropped and sets tx_ovf[2].
  - Channels 0, 1 and 3 are unaffected.
- **Wrap-around:** fill channel 0 TX with 0xA000+k (k=0..7), then pop all 8 (one pop per cycle). Required:
  - D_pop[0] presents 0xA000..0xA007 in order.
  - pndng[0] drops after the 8th pop.
  - Refilling after the pointers have wrapped gives correct ordering.
- **Full plus simultaneous ops:** with TX full, assert wr_en(0xBEEF) and pop together. Required: count stays 8, no tx_ovf, and 0xBEEF is popped last.
- **RX overflow policy:** push 9 packets 0x0100..0x0108 into a full-capacity RX without rd_en. Required:
  - rx_drop_old=0: reads return 0x0100..0x0107.
  - rx_drop_old=1: reads return 0x0101..0x0108.
  - rx_ovf=1 in both cases.
- **Underflow and clear:** pop on empty → udf=1; clr_err → udf=0 the next cycle. With FIFO_STATS_EN defined, drop_cnt is unchanged by clr_err and saturates at 255 after 300 drops.
- **Reset mid-operation:** drop reset to 0 with 5 entries stored. Required: after that edge pndng=0, rx_valid=0 and all flags are 0; a subsequent write 0x1234 appears on D_pop one cycle later.

Source files
------------

// File: rtl/bus_port_fifo_bank.sv
// bus_port_fifo_bank: per-channel TX/RX first-word-fall-through FIFOs between agent side and bus port.
// Define FIFO_STATS_EN to add tx_occ/rx_occ occupancy and saturating drop_cnt outputs.

module bus_port_fifo_chan #(
  parameter int W        = 16,
  parameter int DEPTH    = 8,
  parameter bit DROP_OLD = 1'b0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_i,
  input  logic [W-1:0]                   din_i,
  input  logic                           rd_i,
  output logic [W-1:0]                   head_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o,
  output logic                           ovf_o,
  output logic                           udf_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  head_q, head_d;
  logic          full, empty, wr_acc, rd_acc, ovwr, do_wr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    full    = (count_q == CW'(DEPTH));
    empty   = (count_q == '0);
    rd_acc  = rd_i && !empty;
    wr_acc  = wr_i && (!full || rd_i);
    ovwr    = DROP_OLD && wr_i && full && !rd_i;
    do_wr   = wr_acc || ovwr;
    wptr_d  = do_wr ? ptr_inc(wptr_q) : wptr_q;
    rptr_d  = (rd_acc || ovwr) ? ptr_inc(rptr_q) : rptr_q;
    count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
    // Head register tracks the post-edge head; the incoming word bypasses memory when it becomes the head.
    head_d  = head_q;
    if (count_d != '0)
      head_d = (do_wr && (wptr_q == rptr_d)) ? din_i : mem_q[rptr_d];
    ovf_o   = wr_i && full && !rd_i;
    udf_o   = rd_i && empty;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr)
      mem_q[wptr_q] <= din_i;
  end

  assign head_o  = head_q;
  assign count_o = count_q;
endmodule

module bus_port_fifo_bank #(
  parameter int pckg_sz     = 16,
  parameter int drvrs       = 4,
  parameter int deep_fifo   = 8,
  parameter int af_lvl      = 6,
  parameter int rx_drop_old = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr_err,
  input  logic [drvrs-1:0]           wr_en,
  input  logic [drvrs*pckg_sz-1:0]   wr_data,
  output logic [drvrs-1:0]           tx_full,
  output logic [drvrs-1:0]           tx_afull,
  output logic [drvrs-1:0]           pndng,
  input  logic [drvrs-1:0]           pop,
  output logic [drvrs*pckg_sz-1:0]   D_pop,
  input  logic [drvrs-1:0]           push,
  input  logic [drvrs*pckg_sz-1:0]   D_push,
  input  logic [drvrs-1:0]           rd_en,
  output logic [drvrs-1:0]           rx_valid,
  output logic [drvrs*pckg_sz-1:0]   rd_data,
  output logic [drvrs-1:0]           tx_ovf,
  output logic [drvrs-1:0]           rx_ovf,
  output logic [drvrs-1:0]           udf
`ifdef FIFO_STATS_EN
  ,
  output logic [drvrs*$clog2(deep_fifo+1)-1:0] tx_occ,
  output logic [drvrs*$clog2(deep_fifo+1)-1:0] rx_occ,
  output logic [drvrs*8-1:0]                   drop_cnt
`endif
);
  localparam int CW = $clog2(deep_fifo + 1);

  logic [drvrs-1:0] tx_ovf_evt, rx_ovf_evt, tx_udf_evt, rx_udf_evt;
  logic [drvrs-1:0] tx_ovf_q, rx_ovf_q, udf_q;

  for (genvar g = 0; g < drvrs; g++) begin : g_ch
    logic [CW-1:0] tx_cnt, rx_cnt;

    bus_port_fifo_chan #(.W(pckg_sz), .DEPTH(deep_fifo), .DROP_OLD(1'b0)) u_tx (
      .clk(clk), .reset(reset),
      .wr_i(wr_en[g]), .din_i(wr_data[g*pckg_sz +: pckg_sz]), .rd_i(pop[g]),
      .head_o(D_pop[g*pckg_sz +: pckg_sz]), .count_o(tx_cnt),
      .ovf_o(tx_ovf_evt[g]), .udf_o(tx_udf_evt[g])
    );

    bus_port_fifo_chan #(.W(pckg_sz), .DEPTH(deep_fifo), .DROP_OLD(rx_drop_old != 0)) u_rx (
      .clk(clk), .reset(reset),
      .wr_i(push[g]), .din_i(D_push[g*pckg_sz +: pckg_sz]), .rd_i(rd_en[g]),
      .head_o(rd_data[g*pckg_sz +: pckg_sz]), .count_o(rx_cnt),
      .ovf_o(rx_ovf_evt[g]), .udf_o(rx_udf_evt[g])
    );

    assign pndng[g]    = (tx_cnt != '0);
    assign tx_full[g]  = (tx_cnt == CW'(deep_fifo));
    assign tx_afull[g] = (tx_cnt >= CW'(af_lvl));
    assign rx_valid[g] = (rx_cnt != '0);
`ifdef FIFO_STATS_EN
    assign tx_occ[g*CW +: CW] = tx_cnt;
    assign rx_occ[g*CW +: CW] = rx_cnt;
`endif
  end

  // Set wins over a coincident clr_err.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_ovf_q <= '0;
      rx_ovf_q <= '0;
      udf_q    <= '0;
    end else begin
      tx_ovf_q <= tx_ovf_evt | (tx_ovf_q & ~{drvrs{clr_err}});
      rx_ovf_q <= rx_ovf_evt | (rx_ovf_q & ~{drvrs{clr_err}});
      udf_q    <= tx_udf_evt | rx_udf_evt | (udf_q & ~{drvrs{clr_err}});
    end
  end

  assign tx_ovf = tx_ovf_q;
  assign rx_ovf = rx_ovf_q;
  assign udf    = udf_q;

`ifdef FIFO_STATS_EN
  logic [drvrs-1:0][7:0] drop_q, drop_d;

  always_comb begin
    logic [8:0] sum;
    sum    = '0;
    drop_d = drop_q;
    for (int unsigned i = 0; i < drvrs; i++) begin
      sum       = {1'b0, drop_q[i]} + {8'd0, tx_ovf_evt[i]} + {8'd0, rx_ovf_evt[i]};
      drop_d[i] = sum[8] ? 8'hFF : sum[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) drop_q <= '0;
    else        drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`endif
endmodule

// File: tb/tb_bus_port_fifo_bank.sv
// Bench for bus_port_fifo_bank: two instances (RX discard-new / overwrite-oldest) checked against a queue model.
module tb_bus_port_fifo_bank;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int OW = $clog2(D + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, clr_err;
  logic [N-1:0]     wr_en, pop, push, rd_en;
  logic [N*W-1:0]   wr_data, D_push;

  logic [N-1:0]     o_full[2], o_afull[2], o_pndng[2], o_rxv[2], o_tovf[2], o_rovf[2], o_udf[2];
  logic [N*W-1:0]   o_dpop[2], o_rd[2];
`ifdef FIFO_STATS_EN
  logic [N*OW-1:0]  o_txocc[2], o_rxocc[2];
  logic [N*8-1:0]   o_drop[2];
`endif

  bus_port_fifo_bank #(.pckg_sz(W), .drvrs(N), .deep_fifo(D), .af_lvl(AF), .rx_drop_old(0)) dut0 (
    .clk(clk), .reset(reset), .clr_err(clr_err), .wr_en(wr_en), .wr_data(wr_data),
    .tx_full(o_full[0]), .tx_afull(o_afull[0]), .pndng(o_pndng[0]), .pop(pop), .D_pop(o_dpop[0]),
    .push(push), .D_push(D_push), .rd_en(rd_en), .rx_valid(o_rxv[0]), .rd_data(o_rd[0]),
    .tx_ovf(o_tovf[0]), .rx_ovf(o_rovf[0]), .udf(o_udf[0])
`ifdef FIFO_STATS_EN
    , .tx_occ(o_txocc[0]), .rx_occ(o_rxocc[0]), .drop_cnt(o_drop[0])
`endif
  );

  bus_port_fifo_bank #(.pckg_sz(W), .drvrs(N), .deep_fifo(D), .af_lvl(AF), .rx_drop_old(1)) dut1 (
    .clk(clk), .reset(reset), .clr_err(clr_err), .wr_en(wr_en), .wr_data(wr_data),
    .tx_full(o_full[1]), .tx_afull(o_afull[1]), .pndng(o_pndng[1]), .pop(pop), .D_pop(o_dpop[1]),
    .push(push), .D_push(D_push), .rd_en(rd_en), .rx_valid(o_rxv[1]), .rd_data(o_rd[1]),
    .tx_ovf(o_tovf[1]), .rx_ovf(o_rovf[1]), .udf(o_udf[1])
`ifdef FIFO_STATS_EN
    , .tx_occ(o_txocc[1]), .rx_occ(o_rxocc[1]), .drop_cnt(o_drop[1])
`endif
  );

  // Reference model: packet queues per FIFO, held head words, sticky flags, drop counters.
  logic [W-1:0] mtx[N][$];
  logic [W-1:0] mrx[2][N][$];
  logic [W-1:0] mtxh[N];
  logic [W-1:0] mrxh[2][N];
  logic [N-1:0] mtovf, mrovf, mudf;
  int           mdrop[N];
  int           nvec = 0;
  int           nerr = 0;

  task automatic model_edge();
    for (int c = 0; c < N; c++) begin
      if (!reset) begin
        mtx[c].delete(); mtxh[c] = '0;
        for (int k = 0; k < 2; k++) begin mrx[k][c].delete(); mrxh[k][c] = '0; end
        mtovf[c] = 1'b0; mrovf[c] = 1'b0; mudf[c] = 1'b0; mdrop[c] = 0;
      end else begin
        bit tfull, tempty, tev, tud, rev, rud;
        tfull  = (mtx[c].size() == D);
        tempty = (mtx[c].size() == 0);
        tev    = wr_en[c] && tfull && !pop[c];
        tud    = pop[c] && tempty;
        if (pop[c] && !tempty) void'(mtx[c].pop_front());
        if (wr_en[c] && !tev) mtx[c].push_back(wr_data[c*W +: W]);
        if (mtx[c].size() != 0) mtxh[c] = mtx[c][0];
        rev = 1'b0; rud = 1'b0;
        for (int k = 0; k < 2; k++) begin
          bit rfull, rempty;
          rfull  = (mrx[k][c].size() == D);
          rempty = (mrx[k][c].size() == 0);
          rev    = push[c] && rfull && !rd_en[c];
          rud    = rd_en[c] && rempty;
          if (rd_en[c] && !rempty) void'(mrx[k][c].pop_front());
          if (push[c] && !rev) mrx[k][c].push_back(D_push[c*W +: W]);
          else if (push[c] && k == 1) begin
            void'(mrx[k][c].pop_front());
            mrx[k][c].push_back(D_push[c*W +: W]);
          end
          if (mrx[k][c].size() != 0) mrxh[k][c] = mrx[k][c][0];
        end
        mtovf[c] = tev | (mtovf[c] & !clr_err);
        mrovf[c] = rev | (mrovf[c] & !clr_err);
        mudf[c]  = tud | rud | (mudf[c] & !clr_err);
        mdrop[c] = mdrop[c] + int'(tev) + int'(rev);
        if (mdrop[c] > 255) mdrop[c] = 255;
      end
    end
  endtask

  function automatic logic [N*39-1:0] exp_vec(int k);
    logic [N*39-1:0] v;
    for (int c = 0; c < N; c++)
      v[c*39 +: 39] = {mtx[c].size() != 0, mtx[c].size() == D, mtx[c].size() >= AF,
                       mrx[k][c].size() != 0, mtovf[c], mrovf[c], mudf[c], mtxh[c], mrxh[k][c]};
    return v;
  endfunction

  function automatic logic [N*39-1:0] act_vec(int k);
    logic [N*39-1:0] v;
    for (int c = 0; c < N; c++)
      v[c*39 +: 39] = {o_pndng[k][c], o_full[k][c], o_afull[k][c], o_rxv[k][c],
                       o_tovf[k][c], o_rovf[k][c], o_udf[k][c], o_dpop[k][c*W +: W], o_rd[k][c*W +: W]};
    return v;
  endfunction

  task automatic idle();
    reset = 1'b1; clr_err = 1'b0;
    wr_en = '0; pop = '0; push = '0; rd_en = '0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    idle(); reset = 1'b0; step(); idle();
  endtask

  task automatic test_reset();
    reset = 1'b0; clr_err = 1'b1; wr_en = '1; pop = '1; push = '1; rd_en = '1;
    wr_data = {N*W/32{$urandom()}}; D_push = {N*W/32{$urandom()}};
    step(); step(); idle();
    nvec++;
    if ({act_vec(0), act_vec(1)} !== {exp_vec(0), exp_vec(1)}) begin
      nerr++; $display("FAIL reset_model: got %h expected %h", {act_vec(0), act_vec(1)}, {exp_vec(0), exp_vec(1)});
    end
    nvec++;
    if ({o_pndng[0], o_rxv[0], o_full[0], o_afull[0], o_tovf[0], o_rovf[0], o_udf[0], o_dpop[0], o_rd[0]} !== '0) begin
      nerr++; $display("FAIL reset_zero: got pndng=%b rxv=%b dpop=%h rd=%h required all zero", o_pndng[0], o_rxv[0], o_dpop[0], o_rd[0]);
    end
  endtask

  task automatic test_depth_boundary();
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      wr_en = 4'b0100; wr_data[2*W +: W] = (i == 0) ? 16'h0202 : 16'(i);
      step();
      nvec++;
      if ({act_vec(0), act_vec(1)} !== {exp_vec(0), exp_vec(1)}) begin
        nerr++; $display("FAIL depth_model i=%0d: got %h expected %h", i, act_vec(0), exp_vec(0));
      end
      nvec++;
      if (o_pndng[0][2] !== 1'b1 || o_dpop[0][2*W +: W] !== 16'h0202 || o_afull[0][2] !== (i >= 5) ||
          o_full[0][2] !== (i >= 7) || o_tovf[0][2] !== (i == 8)) begin
        nerr++; $display("FAIL depth_status i=%0d: got pndng=%b dpop=%h afull=%b full=%b ovf=%b", i,
                         o_pndng[0][2], o_dpop[0][2*W +: W], o_afull[0][2], o_full[0][2], o_tovf[0][2]);
      end
    end
    idle(); step();
    nvec++;
    if ((o_pndng[0] & 4'b1011) !== '0 || (o_tovf[0] & 4'b1011) !== '0 || (o_udf[0] | o_rxv[0]) !== '0) begin
      nerr++; $display("FAIL depth_isolation: got pndng=%b tovf=%b udf=%b required others 0", o_pndng[0], o_tovf[0], o_udf[0]);
    end
    for (int i = 0; i < 8; i++) begin
      nvec++;
      if (o_dpop[0][2*W +: W] !== ((i == 0) ? 16'h0202 : 16'(i))) begin
        nerr++; $display("FAIL depth_order i=%0d: got %h", i, o_dpop[0][2*W +: W]);
      end
      pop = 4'b0100; step();
    end
    idle();
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int pass = 0; pass < 2; pass++) begin
      int n;
      n = (pass == 0) ? 8 : 5;
      for (int k = 0; k < n; k++) begin
        wr_en = 4'b0001; wr_data[W-1:0] = 16'hA000 + 16'(k) + 16'(pass * 16'h100); step();
      end
      idle();
      for (int k = 0; k < n; k++) begin
        nvec++;
        if (o_dpop[0][W-1:0] !== 16'hA000 + 16'(k) + 16'(pass * 16'h100) || o_pndng[0][0] !== 1'b1) begin
          nerr++; $display("FAIL wrap_order pass=%0d k=%0d: got %h pndng=%b", pass, k, o_dpop[0][W-1:0], o_pndng[0][0]);
        end
        pop = 4'b0001; step();
      end
      idle();
      nvec++;
      if (o_pndng[0][0] !== 1'b0 || {act_vec(0), act_vec(1)} !== {exp_vec(0), exp_vec(1)}) begin
        nerr++; $display("FAIL wrap_empty pass=%0d: got pndng=%b vec=%h expected %h", pass, o_pndng[0][0], act_vec(0), exp_vec(0));
      end
    end
  endtask

  task automatic test_full_simul();
    logic [W-1:0] last;
    apply_reset();
    for (int k = 0; k < 8; k++) begin wr_en = 4'b0010; wr_data[W +: W] = 16'h1100 + 16'(k); step(); end
    pop = 4'b0010; wr_data[W +: W] = 16'hBEEF; step(); idle();
    nvec++;
    if (o_full[0][1] !== 1'b1 || o_tovf[0][1] !== 1'b0 || o_udf[0][1] !== 1'b0 || o_dpop[0][W +: W] !== 16'h1101) begin
      nerr++; $display("FAIL full_simul: got full=%b ovf=%b udf=%b head=%h", o_full[0][1], o_tovf[0][1], o_udf[0][1], o_dpop[0][W +: W]);
    end
    last = '0;
    for (int k = 0; k < 8; k++) begin last = o_dpop[0][W +: W]; pop = 4'b0010; step(); end
    idle();
    nvec++;
    if (last !== 16'hBEEF || o_pndng[0][1] !== 1'b0 || {act_vec(0), act_vec(1)} !== {exp_vec(0), exp_vec(1)}) begin
      nerr++; $display("FAIL full_last: got last=%h pndng=%b", last, o_pndng[0][1]);
    end
  endtask

  task automatic test_rx_policy();
    apply_reset();
    for (int i = 0; i < 9; i++) begin push = 4'b1000; D_push[3*W +: W] = 16'h0100 + 16'(i); step(); end
    idle();
    nvec++;
    if (o_rovf[0][3] !== 1'b1 || o_rovf[1][3] !== 1'b1 || o_udf[0][3] !== 1'b0) begin
      nerr++; $display("FAIL rx_ovf: got inst0=%b inst1=%b", o_rovf[0][3], o_rovf[1][3]);
    end
    for (int i = 0; i < 8; i++) begin
      nvec++;
      if (o_rd[0][3*W +: W] !== 16'h0100 + 16'(i) || o_rd[1][3*W +: W] !== 16'h0101 + 16'(i)) begin
        nerr++; $display("FAIL rx_policy i=%0d: got drop_new=%h drop_old=%h", i, o_rd[0][3*W +: W], o_rd[1][3*W +: W]);
      end
      rd_en = 4'b1000; step();
    end
    idle();
    nvec++;
    if (o_rxv[0][3] !== 1'b0 || o_rxv[1][3] !== 1'b0 || {act_vec(0), act_vec(1)} !== {exp_vec(0), exp_vec(1)}) begin
      nerr++; $display("FAIL rx_drain: got rxv0=%b rxv1=%b", o_rxv[0][3], o_rxv[1][3]);
    end
  endtask

  task automatic test_underflow_clear();
    apply_reset();
    pop = 4'b0001; wr_en = 4'b0100; wr_data[2*W +: W] = 16'h5A5A; pop[2] = 1'b1; step(); idle(); step();
    nvec++;
    if (o_udf[0] !== 4'b0101 || o_pndng[0][2] !== 1'b1 || o_dpop[0][2*W +: W] !== 16'h5A5A) begin
      nerr++; $display("FAIL udf_set: got udf=%b pndng2=%b head2=%h", o_udf[0], o_pndng[0][2], o_dpop[0][2*W +: W]);
    end
    clr_err = 1'b1; rd_en = 4'b0010; step(); idle();
    nvec++;
    if (o_udf[0] !== 4'b0010 || o_udf[1] !== 4'b0010) begin
      nerr++; $display("FAIL udf_clear: got udf=%b required 0010", o_udf[0]);
    end
    clr_err = 1'b1; step(); idle();
    nvec++;
    if (o_udf[0] !== 4'b0000) begin
      nerr++; $display("FAIL udf_clear2: got udf=%b required 0000", o_udf[0]);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      wr_en = 4'b1000; wr_data[3*W +: W] = 16'(k + 7); push = 4'b0001; D_push[W-1:0] = 16'(k); pop[1] = 1'b1; step();
    end
    idle(); reset = 1'b0; wr_en = 4'b1111; push = 4'b1111; step(); idle();
    nvec++;
    if (o_pndng[0] !== '0 || o_rxv[0] !== '0 || (o_tovf[0] | o_rovf[0] | o_udf[0]) !== '0 || o_dpop[0] !== '0) begin
      nerr++; $display("FAIL reset_mid: got pndng=%b rxv=%b udf=%b dpop=%h", o_pndng[0], o_rxv[0], o_udf[0], o_dpop[0]);
    end
    wr_en = 4'b1000; wr_data[3*W +: W] = 16'h1234; step(); idle();
    nvec++;
    if (o_dpop[0][3*W +: W] !== 16'h1234 || o_pndng[0] !== 4'b1000) begin
      nerr++; $display("FAIL reset_mid_write: got head=%h pndng=%b", o_dpop[0][3*W +: W], o_pndng[0]);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int c = 0; c < N; c++) begin
        wr_en[c] = ($urandom_range(0, 9) < 6);
        pop[c]   = ($urandom_range(0, 9) < 4);
        push[c]  = ($urandom_range(0, 9) < 6);
        rd_en[c] = ($urandom_range(0, 9) < 4);
        wr_data[c*W +: W] = 16'($urandom());
        D_push[c*W +: W]  = 16'($urandom());
      end
      clr_err = ($urandom_range(0, 15) == 0);
      reset   = ($urandom_range(0, 99) != 0);
      step();
      nvec++;
      if ({act_vec(0), act_vec(1)} !== {exp_vec(0), exp_vec(1)}) begin
        nerr++; $display("FAIL random cyc=%0d: got %h/%h expected %h/%h", cyc, act_vec(0), act_vec(1), exp_vec(0), exp_vec(1));
      end
`ifdef FIFO_STATS_EN
      for (int c = 0; c < N; c++) begin
        nvec++;
        if (o_txocc[0][c*OW +: OW] !== OW'(mtx[c].size()) || o_rxocc[1][c*OW +: OW] !== OW'(mrx[1][c].size()) ||
            o_drop[0][c*8 +: 8] !== 8'(mdrop[c])) begin
          nerr++; $display("FAIL random_stats cyc=%0d ch=%0d: got occ=%0d drop=%0d", cyc, c, o_txocc[0][c*OW +: OW], o_drop[0][c*8 +: 8]);
        end
      end
`endif
    end
    idle();
  endtask

`ifdef FIFO_STATS_EN
  task automatic test_stats();
    apply_reset();
    for (int k = 0; k < 8; k++) begin wr_en = 4'b0001; wr_data[W-1:0] = 16'(k); step(); end
    for (int k = 0; k < 300; k++) begin wr_en = 4'b0001; step(); end
    idle(); clr_err = 1'b1; step(); idle();
    nvec++;
    if (o_drop[0][7:0] !== 8'd255 || o_drop[1][7:0] !== 8'd255 || o_tovf[0][0] !== 1'b0 || o_txocc[0][OW-1:0] !== OW'(8)) begin
      nerr++; $display("FAIL stats_sat: got drop=%0d ovf=%b occ=%0d", o_drop[0][7:0], o_tovf[0][0], o_txocc[0][OW-1:0]);
    end
  endtask
`endif

  initial begin
    idle();
    wr_data = '0; D_push = '0;
    test_reset();
    test_depth_boundary();
    test_wrap();
    test_full_simul();
    test_rx_policy();
    test_underflow_clear();
    test_reset_mid();
    test_random();
`ifdef FIFO_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
